// File: rtl/pr_arbiter.sv
// pr_arbiter: registered N-way priority arbiter with a valid/ready grant handshake.
// A grant is held while the consumer stalls, and reloaded on the cycle it transfers.
// When the grant reloads, mode chooses the policy:
//   mode = 0: fixed priority, highest index wins.
//   mode = 1: round-robin, scanning upward from ptr.
//
// Ports:
//   clk         rising-edge clock
//   rst         synchronous active-high reset
//   req[N]      level-sensitive request vector, bit i = requester i
//   mode        0 = fixed priority, 1 = round-robin (sampled only on load)
//   gnt_ready   consumer accepts the presented grant
//   gnt_valid   a grant is presented
//   gnt_idx[W]  index of the granted requester (0 when idle)
//   gnt_onehot  one-hot form of gnt_idx, all-zero when idle
module pr_arbiter #(
    parameter int unsigned N = 8,
    parameter int unsigned W = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic         mode,
    input  logic         gnt_ready,
    output logic         gnt_valid,
    output logic [W-1:0] gnt_idx,
    output logic [N-1:0] gnt_onehot
);

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_e;

    state_e       state_q, state_d;
    logic [W-1:0] idx_q, idx_d;
    logic [N-1:0] onehot_q, onehot_d;
    logic [W-1:0] ptr_q, ptr_d;

    logic [W-1:0] fix_idx;
    logic [W-1:0] rr_idx;
    logic         rr_found;
    logic [W-1:0] win_idx;
    logic [W-1:0] ptr_nxt;
    logic         any_req;
    logic         load;

    // Fixed priority: the last set bit seen in the ascending scan is the highest.
    always_comb begin
        fix_idx = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (req[i]) begin
                fix_idx = W'(i);
            end
        end
    end

    // Round-robin: scan upward from ptr. The wrap subtracts N explicitly,
    // so a non-power-of-two N never lands on an index that does not exist.
    always_comb begin
        logic [W-1:0] cand_idx;
        int unsigned  cand;
        rr_idx   = '0;
        rr_found = 1'b0;
        cand     = 0;
        cand_idx = '0;
        for (int unsigned k = 0; k < N; k++) begin
            cand = 32'(ptr_q) + k;
            if (cand >= N) begin
                cand = cand - N;
            end
            cand_idx = W'(cand);
            if (!rr_found && req[cand_idx]) begin
                rr_found = 1'b1;
                rr_idx   = cand_idx;
            end
        end
    end

    assign any_req = |req;
    assign win_idx = mode ? rr_idx : fix_idx;

    // The pointer advances to the slot after the winner, wrapping at N rather than at 2**W.
    assign ptr_nxt = (win_idx == W'(N - 1)) ? '0 : win_idx + W'(1);

    // A new grant is taken when nothing is presented or the current one transfers.
    assign load = (state_q == ST_EMPTY) || gnt_ready;

    // Next-state and registered-output logic.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        onehot_d = onehot_q;
        ptr_d    = ptr_q;

        unique case (state_q)
            ST_EMPTY, ST_FULL: begin
                if (load) begin
                    if (any_req) begin
                        state_d           = ST_FULL;
                        idx_d             = win_idx;
                        onehot_d          = '0;
                        onehot_d[win_idx] = 1'b1;
                        if (mode) begin
                            ptr_d = ptr_nxt;
                        end
                    end else begin
                        state_d  = ST_EMPTY;
                        idx_d    = '0;
                        onehot_d = '0;
                    end
                end
            end
            default: begin
                state_d  = ST_EMPTY;
                idx_d    = '0;
                onehot_d = '0;
            end
        endcase
    end

    // State register. Reset wins over a grant that is being held during a stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_EMPTY;
            idx_q    <= '0;
            onehot_q <= '0;
            ptr_q    <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            onehot_q <= onehot_d;
            ptr_q    <= ptr_d;
        end
    end

    assign gnt_valid  = (state_q == ST_FULL);
    assign gnt_idx    = idx_q;
    assign gnt_onehot = onehot_q;

endmodule

// File: tb/tb_pr_arbiter.sv
// Directed bench for pr_arbiter. The main instance uses N=8.
// A second instance uses N=6 to exercise the wrap for a non-power-of-two N.
module tb_pr_arbiter;

    logic       clk;
    logic       rst;
    logic [7:0] req;
    logic       mode;
    logic       gnt_ready;
    logic       gnt_valid;
    logic [2:0] gnt_idx;
    logic [7:0] gnt_onehot;

    logic [5:0] req6;
    logic       mode6;
    logic       ready6;
    logic       valid6;
    logic [2:0] idx6;
    logic [5:0] onehot6;

    int checks   = 0;
    int failures = 0;

    pr_arbiter #(.N(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .mode       (mode),
        .gnt_ready  (gnt_ready),
        .gnt_valid  (gnt_valid),
        .gnt_idx    (gnt_idx),
        .gnt_onehot (gnt_onehot)
    );

    pr_arbiter #(.N(6)) dut6 (
        .clk        (clk),
        .rst        (rst),
        .req        (req6),
        .mode       (mode6),
        .gnt_ready  (ready6),
        .gnt_valid  (valid6),
        .gnt_idx    (idx6),
        .gnt_onehot (onehot6)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge, then settle so outputs are sampled away from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_grant(input string tag, input logic v, input logic [2:0] idx, input logic [7:0] oh);
        chk({tag, "_valid"},  32'(gnt_valid),  32'(v));
        chk({tag, "_idx"},    32'(gnt_idx),    32'(idx));
        chk({tag, "_onehot"}, 32'(gnt_onehot), 32'(oh));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [2:0] sweep [9];
        sweep = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0};

        // Reset with every input trying to provoke a grant.
        rst = 1'b1; req = 8'hFF; mode = 1'b1; gnt_ready = 1'b0;
        req6 = '0; mode6 = 1'b1; ready6 = 1'b1;
        #1;
        tick();
        tick();
        chk_grant("reset", 1'b0, 3'd0, 8'h00);

        // First grant after reset starts at ptr=0.
        rst = 1'b0;
        tick();
        chk_grant("post_reset", 1'b1, 3'd0, 8'h01);

        // Fixed priority.
        mode = 1'b0; gnt_ready = 1'b1; req = 8'b1010_0110;
        tick();
        chk_grant("fixed_a6", 1'b1, 3'd7, 8'h80);
        req = 8'h06;
        tick();
        chk_grant("fixed_06", 1'b1, 3'd2, 8'h04);
        req = 8'h00;
        tick();
        chk_grant("fixed_none", 1'b0, 3'd0, 8'h00);

        // Stall hold: the grant ignores req changes until ready.
        gnt_ready = 1'b0; req = 8'h10;
        tick();
        chk_grant("stall_load", 1'b1, 3'd4, 8'h10);
        req = 8'h80;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk_grant("stall_hold", 1'b1, 3'd4, 8'h10);
        end
        gnt_ready = 1'b1;
        tick();
        chk_grant("stall_release", 1'b1, 3'd7, 8'h80);

        // Park ptr at 0 by round-robin granting idx 7, then sweep.
        mode = 1'b1; req = 8'h80;
        tick();
        chk_grant("rr_park", 1'b1, 3'd7, 8'h80);
        req = 8'hFF;
        for (int s = 0; s < 9; s++) begin
            tick();
            chk_grant("rr_sweep", 1'b1, sweep[s], 8'h01 << sweep[s]);
        end

        // Round-robin wrap: 5 leaves ptr=6, then 0x03 wraps to 0, then 1.
        req = 8'h20;
        tick();
        chk_grant("rr_wrap5", 1'b1, 3'd5, 8'h20);
        req = 8'h03;
        tick();
        chk_grant("rr_wrap0", 1'b1, 3'd0, 8'h01);
        tick();
        chk_grant("rr_wrap1", 1'b1, 3'd1, 8'h02);

        // N=6: granting 5 must wrap ptr to 0, not to 6.
        req6 = 6'h20;
        tick();
        chk("n6_idx5", 32'(idx6), 32'd5);
        chk("n6_onehot5", 32'(onehot6), 32'h20);
        req6 = 6'h3F;
        tick();
        chk("n6_idx0", 32'(idx6), 32'd0);
        chk("n6_onehot0", 32'(onehot6), 32'h01);
        tick();
        chk("n6_idx1", 32'(idx6), 32'd1);
        req6 = '0;
        tick();
        chk("n6_empty", 32'(valid6), 32'd0);

        // Reset while a grant is held mid-stall.
        mode = 1'b0; req = 8'h08;
        tick();
        chk_grant("mid_load", 1'b1, 3'd3, 8'h08);
        gnt_ready = 1'b0; rst = 1'b1;
        tick();
        chk_grant("mid_reset", 1'b0, 3'd0, 8'h00);
        rst = 1'b0; req = 8'h09; mode = 1'b1;
        tick();
        chk_grant("mid_after", 1'b1, 3'd0, 8'h01);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
